// File: rtl/asrv32_dmem_bridge.sv
// asrv32_dmem_bridge: core load/store to registered valid/ready bus transaction with response phase and timeout
module asrv32_dmem_bridge #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wmask,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic        o_bus_valid,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_addr,
    output logic        o_bus_we,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wstrb,
    input  logic        i_bus_rsp_valid,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic capture, accept, complete, timeout;
    logic unused_addr;
    assign unused_addr = ^i_addr[1:0];
    always_comb begin
        capture = state == IDLE && i_req && !o_done;
        accept = state == REQ && i_bus_ready;
        complete = state == RSP && i_bus_rsp_valid;
        // a response landing on the timeout edge still completes normally
        timeout = TIMEOUT_CYCLES != 0 && state != IDLE && cnt == CNT_LAST && !complete;
        state_nx = (complete || timeout) ? IDLE : capture ? REQ : accept ? RSP : state;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_err <= 1'b0;
            o_rdata <= '0;
            o_bus_valid <= 1'b0;
            o_bus_addr <= '0;
            o_bus_we <= 1'b0;
            o_bus_wdata <= '0;
            o_bus_wstrb <= '0;
        end else begin
            cnt <= (state == IDLE) ? '0 : cnt + 1'b1;
            o_done <= complete || timeout;
            if (capture) begin
                o_bus_addr <= {i_addr[31:2], 2'b00};
                o_bus_we <= i_we;
                o_bus_wdata <= i_wdata;
                o_bus_wstrb <= i_we ? i_wmask : 4'b0000;
                o_bus_valid <= 1'b1;
                o_busy <= 1'b1;
                o_err <= 1'b0;
            end
            if (accept || timeout) o_bus_valid <= 1'b0;
            if (complete) begin
                o_rdata <= o_bus_we ? o_rdata : i_bus_rdata;
                o_err <= i_bus_err;
                o_busy <= 1'b0;
            end
            if (timeout) begin
                o_err <= 1'b1;
                o_busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_asrv32_dmem_bridge.sv
// tb_asrv32_dmem_bridge: table-driven transactions plus timeout, stray response and reset sequences
module tb_asrv32_dmem_bridge;
    logic        i_clk = 1'b0, i_rst = 1'b1;
    logic        i_req = 1'b0, i_we = 1'b0;
    logic [31:0] i_addr = '0, i_wdata = '0;
    logic [3:0]  i_wmask = '0;
    logic        o_busy, o_done, o_err, o_bus_valid, o_bus_we;
    logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_wstrb;
    logic        i_bus_ready = 1'b0, i_bus_rsp_valid = 1'b0, i_bus_err = 1'b0;
    logic [31:0] i_bus_rdata = '0;
    int n_chk = 0, n_fail = 0, cyc = 0, n_req = 0, n_done = 0;

    always #5 i_clk = ~i_clk;

    asrv32_dmem_bridge #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_wmask(i_wmask), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err), .o_rdata(o_rdata), .o_bus_valid(o_bus_valid), .i_bus_ready(i_bus_ready),
        .o_bus_addr(o_bus_addr), .o_bus_we(o_bus_we), .o_bus_wdata(o_bus_wdata),
        .o_bus_wstrb(o_bus_wstrb), .i_bus_rsp_valid(i_bus_rsp_valid),
        .i_bus_rdata(i_bus_rdata), .i_bus_err(i_bus_err)
    );

    always @(negedge i_clk) if (o_done) n_done++;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          rd;
        int          rsp;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tv[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic run(input vec_t v);
        int t0;
        i_req = 1'b1; i_we = v.we; i_addr = v.addr; i_wdata = v.wdata; i_wmask = v.mask;
        t0 = cyc;
        n_req++;
        step;
        i_addr = ~v.addr; i_we = ~v.we;
        chk("busy", o_busy, 1);
        chk("err_clear", o_err, 0);
        for (int k = 0; k <= v.rd; k++) begin
            i_bus_ready = (k == v.rd);
            chk("valid", o_bus_valid, 1);
            chk("bus_addr", o_bus_addr, v.exp_addr);
            chk("bus_wstrb", o_bus_wstrb, v.exp_wstrb);
            chk("bus_we", o_bus_we, v.we);
            chk("bus_wdata", o_bus_wdata, v.wdata);
            step;
            i_req = 1'b0;
        end
        i_bus_ready = 1'b0;
        for (int k = 0; k <= v.rsp; k++) begin
            chk("valid_drop", o_bus_valid, 0);
            chk("busy_rsp", o_busy, 1);
            chk("no_early_done", o_done, 0);
            i_bus_rsp_valid = (k == v.rsp);
            i_bus_rdata = (k == v.rsp) ? v.rdata : 32'h0BAD_0BAD;
            i_bus_err = (k == v.rsp) ? v.err : 1'b1;
            step;
        end
        i_bus_rsp_valid = 1'b0; i_bus_err = 1'b0;
        chk("done", o_done, 1);
        chk("err", o_err, v.exp_err);
        chk("rdata", o_rdata, v.exp_rdata);
        chk("busy_off", o_busy, 0);
        chk("latency", cyc - t0, v.exp_lat);
        i_req = 1'b1; i_addr = 32'h0000_0BAD; i_we = 1'b0;
        step;
        i_req = 1'b0;
        chk("done_pulse", o_done, 0);
        chk("req_in_done_ignored", {o_busy, o_bus_valid}, 0);
        chk("rdata_hold", o_rdata, v.exp_rdata);
        chk("err_hold", o_err, v.exp_err);
    endtask

    task automatic run_tmo(input int ready_at, input logic [31:0] exp_rdata);
        int t0;
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0500; i_wmask = 4'b1111;
        t0 = cyc;
        n_req++;
        step;
        i_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("tmo_no_done", o_done, 0);
            chk("tmo_valid", o_bus_valid, (ready_at < 0 || k <= ready_at) ? 1 : 0);
            i_bus_ready = (k == ready_at);
            step;
        end
        i_bus_ready = 1'b0;
        chk("tmo_done", o_done, 1);
        chk("tmo_err", o_err, 1);
        chk("tmo_valid_drop", o_bus_valid, 0);
        chk("tmo_busy", o_busy, 0);
        chk("tmo_rdata", o_rdata, exp_rdata);
        chk("tmo_latency", cyc - t0, 9);
        step;
        chk("tmo_pulse", o_done, 0);
        i_bus_rsp_valid = 1'b1; i_bus_rdata = 32'h7777_7777;
        step;
        i_bus_rsp_valid = 1'b0;
        chk("stray_rsp_no_done", o_done, 0);
        chk("stray_rsp_rdata", o_rdata, exp_rdata);
        chk("stray_rsp_idle", o_busy, 0);
    endtask

    initial begin
        tv[0] = '{1'b0, 32'h0000_1006, 32'h1234_5678, 4'b1111, 0, 0, 32'hDEAD_BEEF, 1'b0,
                  32'h0000_1004, 4'b0000, 32'hDEAD_BEEF, 1'b0, 3};
        tv[1] = '{1'b1, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 4, 2, 32'h5555_5555, 1'b0,
                  32'h0000_0020, 4'b0010, 32'hDEAD_BEEF, 1'b0, 9};
        tv[2] = '{1'b0, 32'h0000_3003, 32'h0, 4'b0001, 1, 1, 32'hCAFE_F00D, 1'b1,
                  32'h0000_3000, 4'b0000, 32'hCAFE_F00D, 1'b1, 5};
        tv[3] = '{1'b0, 32'h0000_0040, 32'h0, 4'b1111, 0, 0, 32'h0102_0304, 1'b0,
                  32'h0000_0040, 4'b0000, 32'h0102_0304, 1'b0, 3};
        tv[4] = '{1'b1, 32'hFFFF_FFFE, 32'hBEEF_0000, 4'b1100, 0, 3, 32'h9999_9999, 1'b1,
                  32'hFFFF_FFFC, 4'b1100, 32'h0102_0304, 1'b1, 6};
        step;
        step;
        chk("rst_outputs", {o_busy, o_done, o_err, o_bus_valid, o_bus_we, o_bus_wstrb}, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_bus_addr", o_bus_addr, 0);
        chk("rst_bus_wdata", o_bus_wdata, 0);
        i_rst = 1'b0;
        step;
        chk("idle_no_req", {o_busy, o_bus_valid}, 0);
        foreach (tv[i]) run(tv[i]);
        run_tmo(-1, 32'h0102_0304);
        run_tmo(2, 32'h0102_0304);
        i_req = 1'b1; i_we = 1'b0; i_addr = 32'h0000_0600;
        step;
        i_req = 1'b0; i_bus_ready = 1'b1;
        step;
        i_bus_ready = 1'b0;
        step;
        i_rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", {o_busy, o_done, o_bus_valid}, 0);
        chk("rst_mid_addr", o_bus_addr, 0);
        chk("rst_mid_rdata", o_rdata, 0);
        step;
        step;
        i_rst = 1'b0;
        run('{1'b0, 32'h0000_0704, 32'h0, 4'b1111, 0, 1, 32'h1357_9BDF, 1'b0,
              32'h0000_0704, 4'b0000, 32'h1357_9BDF, 1'b0, 4});
        step;
        chk("done_count", n_done, n_req);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
